// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous memory port (1-cycle read latency) between two
// requesters: m0 (core fetch/load/store) and m1 (boot loader / debug DMA).
// Every access walks IDLE -> ACCESS -> RESP. Arbitration is round-robin, or
// fixed m0 priority when FIXED_PRIO=1. The winner receives registered read
// data and a one-cycle done pulse in the IDLE cycle that follows RESP.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   mX_addr/wdata/wmask  requester command (held stable until mX_done)
//   mX_rstrb             requester read request (level)
//   mX_rdata             last read data returned to requester X
//   mX_done              one-cycle completion pulse to requester X
//   mem_addr/wdata/...   registered command towards the memory
//   mem_rdata            memory read data, valid the cycle after mem_rstrb
//   grant_m1             owner of the current/last access (0 = m0, 1 = m1)
module mem_port_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter logic        RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    output logic        grant_m1
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic        r_last;       // last-grant pointer (1 = m1 was granted last)
    logic        r_is_read;    // current access returns data
    logic        r_grant_m1;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic        r_mem_rstrb;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_m0_done;
    logic        r_m1_done;

    logic        w_req0;
    logic        w_req1;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant;
    logic        w_pick_m1;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wmask;
    logic        w_sel_rstrb;

    // Arbitration. A requester whose done is high this cycle still holds its
    // request level for one cycle; masking it stops that being re-granted and
    // makes grants alternate under continuous contention.
    always_comb begin
        w_req0    = m0_rstrb | (|m0_wmask);
        w_req1    = m1_rstrb | (|m1_wmask);
        w_elig0   = w_req0 & ~r_m0_done;
        w_elig1   = w_req1 & ~r_m1_done;
        w_grant   = w_elig0 | w_elig1;
        w_pick_m1 = w_elig1;
        if (w_elig0 && w_elig1) begin
            w_pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end

        w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
        w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
        w_sel_wmask = w_pick_m1 ? m1_wmask : m0_wmask;
        w_sel_rstrb = w_pick_m1 ? m1_rstrb : m0_rstrb;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_grant) w_state_next = StAccess;
            StAccess: w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last      <= RESET_LAST;
            r_is_read   <= 1'b0;
            r_grant_m1  <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wmask <= 4'h0;
            r_mem_rstrb <= 1'b0;
            r_m0_rdata  <= 32'h0;
            r_m1_rdata  <= 32'h0;
            r_m0_done   <= 1'b0;
            r_m1_done   <= 1'b0;
        end else begin
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_wmask <= w_sel_wmask;
                        // A write that also raises rstrb is treated as a write only.
                        r_mem_rstrb <= w_sel_rstrb & ~(|w_sel_wmask);
                        r_is_read   <= w_sel_rstrb & ~(|w_sel_wmask);
                        r_grant_m1  <= w_pick_m1;
                        r_last      <= w_pick_m1;
                    end
                end
                StAccess: begin
                    r_mem_rstrb <= 1'b0;
                    r_mem_wmask <= 4'h0;
                end
                StResp: begin
                    if (r_grant_m1) begin
                        r_m1_done <= 1'b1;
                        if (r_is_read) r_m1_rdata <= mem_rdata;
                    end else begin
                        r_m0_done <= 1'b1;
                        if (r_is_read) r_m0_rdata <= mem_rdata;
                    end
                end
                default: begin
                    r_mem_rstrb <= 1'b0;
                    r_mem_wmask <= 4'h0;
                end
            endcase
        end
    end

    assign m0_rdata  = r_m0_rdata;
    assign m0_done   = r_m0_done;
    assign m1_rdata  = r_m1_rdata;
    assign m1_done   = r_m1_done;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign mem_rstrb = r_mem_rstrb;
    assign grant_m1  = r_grant_m1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. A round-robin instance
// drives a small synchronous memory model; a fixed-priority instance shares
// the same requester stimulus and is only observed for its grant decisions.
module tb_mem_port_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rstrb, m1_rstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        grant_m1;

    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
    logic        fp_m0_done, fp_m1_done, fp_mem_rstrb, fp_grant_m1;
    logic [3:0]  fp_mem_wmask;

    logic [31:0] mem [64];

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;

    mem_port_arbiter #(.FIXED_PRIO(0), .RESET_LAST(1'b1)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .grant_m1(grant_m1)
    );

    mem_port_arbiter #(.FIXED_PRIO(1), .RESET_LAST(1'b1)) u_dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(fp_m0_rdata), .m0_done(fp_m0_done),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(fp_m1_rdata), .m1_done(fp_m1_done),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
        .mem_rstrb(fp_mem_rstrb), .mem_rdata(32'h0), .grant_m1(fp_grant_m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        logic exp_d0, exp_d1, exp_g;
        resetn   = 1'b0;
        m0_addr  = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0; m0_rstrb = 1'b0;
        m1_addr  = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0; m1_rstrb = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]  = 32'h1111_1111;
        mem[2]  = 32'h2222_2222;
        mem[4]  = 32'hDEAD_BEEF;
        mem[8]  = 32'hAAAA_AAAA;

        // Reset state.
        step();
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_mem_rstrb", mem_rstrb, 1'b0);
        chk32("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk1("rst_grant", grant_m1, 1'b0);
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        chk1("rst_m0_done", m0_done, 1'b0);
        chk1("rst_m1_done", m1_done, 1'b0);
        resetn = 1'b1;

        // 1: m0 read of 0x10.
        m0_addr = 32'h10; m0_rstrb = 1'b1;
        step();
        chk32("t1_addr", mem_addr, 32'h10);
        chk1("t1_rstrb_t1", mem_rstrb, 1'b1);
        chk1("t1_grant", grant_m1, 1'b0);
        chk1("t1_done_t1", m0_done, 1'b0);
        step();
        chk1("t1_rstrb_t2", mem_rstrb, 1'b0);
        chk1("t1_done_t2", m0_done, 1'b0);
        step();
        chk1("t1_done_t3", m0_done, 1'b1);
        chk32("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk1("t1_m1_done", m1_done, 1'b0);
        chk32("t1_m1_rdata", m1_rdata, 32'h0);
        m0_rstrb = 1'b0;
        step();
        chk1("t1_done_t4", m0_done, 1'b0);
        chk1("t1_idle_rstrb", mem_rstrb, 1'b0);

        // 2: m1 write with rstrb also high is a write only.
        m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wmask = 4'b0011; m1_rstrb = 1'b1;
        step();
        chk32("t2_wmask", {28'h0, mem_wmask}, 32'h3);
        chk1("t2_rstrb", mem_rstrb, 1'b0);
        chk32("t2_wdata", mem_wdata, 32'h1234_5678);
        chk1("t2_grant", grant_m1, 1'b1);
        step();
        chk32("t2_wmask_t2", {28'h0, mem_wmask}, 32'h0);
        chk1("t2_done_t2", m1_done, 1'b0);
        step();
        chk1("t2_done_t3", m1_done, 1'b1);
        chk32("t2_m1_rdata", m1_rdata, 32'h0);
        chk32("t2_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
        chk32("t2_mem_word", mem[8], 32'hAAAA_5678);
        m1_wmask = 4'h0; m1_rstrb = 1'b0;
        step();
        chk1("t2_done_t4", m1_done, 1'b0);

        // 3: simultaneous reads after reset, m0 first.
        do_reset();
        m0_addr = 32'h4; m0_rstrb = 1'b1;
        m1_addr = 32'h8; m1_rstrb = 1'b1;
        step();
        chk1("t3_grant_first", grant_m1, 1'b0);
        chk32("t3_addr_first", mem_addr, 32'h4);
        step();
        step();
        chk1("t3_m0_done", m0_done, 1'b1);
        chk32("t3_m0_rdata", m0_rdata, 32'h1111_1111);
        m0_rstrb = 1'b0;
        step();
        chk1("t3_grant_second", grant_m1, 1'b1);
        chk32("t3_addr_second", mem_addr, 32'h8);
        chk1("t3_rstrb_second", mem_rstrb, 1'b1);
        step();
        chk1("t3_m1_done_t5", m1_done, 1'b0);
        step();
        chk1("t3_m1_done_t6", m1_done, 1'b1);
        chk32("t3_m1_rdata", m1_rdata, 32'h2222_2222);
        m1_rstrb = 1'b0;
        step();

        // 4: continuous contention alternates grants.
        do_reset();
        m0_addr = 32'h4; m0_rstrb = 1'b1;
        m1_addr = 32'h8; m1_rstrb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_d0 = (k == 3) || (k == 9);
            exp_d1 = (k == 6) || (k == 12);
            exp_g  = ((k - 1) / 3) % 2 == 1;
            chk1($sformatf("t4_m0_done_k%0d", k), m0_done, exp_d0);
            chk1($sformatf("t4_m1_done_k%0d", k), m1_done, exp_d1);
            chk1($sformatf("t4_grant_k%0d", k), grant_m1, exp_g);
            if (m0_done) n_done++;
            if (m1_done) n_done++;
        end
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        chk32("t4_done_count", n_done, 4);
        step();
        chk1("t4_idle_rstrb", mem_rstrb, 1'b0);
        chk1("t4_idle_done", m1_done, 1'b0);

        // 5: pointer-driven tie-break vs fixed priority.
        do_reset();
        m1_addr = 32'h8; m1_rstrb = 1'b1;
        step();
        chk1("t5_m1_alone_grant", grant_m1, 1'b1);
        step();
        step();
        chk1("t5_m1_alone_done", m1_done, 1'b1);
        m1_rstrb = 1'b0;
        step();
        m0_addr = 32'h4; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        step();
        chk1("t5_rr_after_m1", grant_m1, 1'b0);
        chk1("t5_fp_after_m1", fp_grant_m1, 1'b0);
        step();
        step();
        chk1("t5_m0_done", m0_done, 1'b1);
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step();
        m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        step();
        chk1("t5_rr_after_m0", grant_m1, 1'b1);
        chk1("t5_fp_after_m0", fp_grant_m1, 1'b0);
        step();
        step();
        chk1("t5_rr_done", m1_done, 1'b1);
        chk1("t5_fp_done", fp_m0_done, 1'b1);
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step();

        // 6: asynchronous reset in the middle of an m0 read.
        do_reset();
        m0_addr = 32'h10; m0_rstrb = 1'b1;
        step();
        chk1("t6_access_rstrb", mem_rstrb, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk32("t6_async_addr", mem_addr, 32'h0);
        chk1("t6_async_rstrb", mem_rstrb, 1'b0);
        chk1("t6_async_grant", grant_m1, 1'b0);
        chk1("t6_async_done", m0_done, 1'b0);
        step();
        chk1("t6_rst_done", m0_done, 1'b0);
        resetn = 1'b1;
        step();
        chk1("t6_i1_rstrb", mem_rstrb, 1'b1);
        chk1("t6_i1_done", m0_done, 1'b0);
        step();
        chk1("t6_i2_done", m0_done, 1'b0);
        step();
        chk1("t6_i3_done", m0_done, 1'b1);
        chk32("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_rstrb = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port (1-cycle read latency) between two requesters.
  - Port m0: processor core fetch/load/store.
  - Port m1: boot loader / debug DMA.
- Sequences each access through a fixed three-state cycle.
- Arbitrates with round-robin by default, or fixed m0 priority.
- Returns registered read data and a one-cycle completion pulse to the winning requester.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.
- RESET_LAST, 1: reset value of last-grant pointer (1 = m0 wins the first round-robin tie).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- m0_addr  in  32  m0 byte address (word-aligned)
- m0_wdata  in  32  m0 write data
- m0_wmask  in  4  m0 byte write enables; nonzero = write request
- m0_rstrb  in  1  m0 read request (level)
- m0_rdata  out  32  m0 last read data (registered)
- m0_done  out  1  m0 transaction complete pulse
- m1_addr  in  32  m1 byte address
- m1_wdata  in  32  m1 write data
- m1_wmask  in  4  m1 byte write enables
- m1_rstrb  in  1  m1 read request
- m1_rdata  out  32  m1 last read data (registered)
- m1_done  out  1  m1 transaction complete pulse
- mem_addr  out  32  memory address (registered)
- mem_wdata  out  32  memory write data (registered)
- mem_wmask  out  4  memory byte write enables (registered)
- mem_rstrb  out  1  memory read strobe (registered)
- mem_rdata  in  32  memory read data, valid the cycle after the strobe
- grant_m1  out  1  owner of current/last access (0 = m0, 1 = m1)

Behaviour:
- Reset (async, resetn=0): state=IDLE.
  - All mem_* outputs = 0; m0_rdata = m1_rdata = 0; m0_done = m1_done = 0.
  - grant_m1 = 0; last-grant pointer = RESET_LAST.
  - Any in-flight access is abandoned; no done is issued for it.
- Request: reqX = mX_rstrb | (mX_wmask != 0).
  - Level-sensitive; requester holds addr/wdata/wmask/rstrb stable until mX_done.
- Done masking: in IDLE, a requester whose done is high this cycle is ignored. A request still high the following cycle is a new transaction.
- State IDLE:
  - One eligible requester: grant it.
  - Both eligible: FIXED_PRIO=1 grants m0; otherwise grant the one not equal to the last-grant pointer.
  - On grant: latch winner's addr/wdata/wmask into mem_*.
    - mem_rstrb = winner rstrb & (wmask==0). A write with rstrb also high is a write only; no read data is updated.
    - Set grant_m1; update pointer; go to ACCESS.
  - No grant: mem_rstrb/mem_wmask stay 0.
- State ACCESS: command visible to memory for exactly this one cycle. On exit, clear mem_rstrb and mem_wmask; mem_addr/mem_wdata hold. Go to RESP.
- State RESP: mem_rdata valid.
  - If the access was a read: winner's rdata <= mem_rdata at the end of this cycle.
  - Winner's done <= 1 (high for exactly one cycle, the next IDLE cycle). Go to IDLE.
- Done/rdata: mX_done is a registered pulse, never high on both ports at once. mX_rdata holds its value until the next read by that port.
- Latency and throughput:
  - Request seen in IDLE at cycle T: ACCESS at T+1, RESP at T+2, done at T+3.
  - The next grant can be made in cycle T+3, so one access completes every 3 cycles at full load.
- Fairness: done masking alternates grants under continuous contention even with FIXED_PRIO=1.
- Address: passed through unmodified (no alignment checking); width 32, no wrap logic.
- States are encoded in 2 bits; the unused encoding returns to IDLE.

Test Plan:
1. m0 read, addr 0x10, memory model returns 0xDEADBEEF; request at T -> mem_addr=0x10 and mem_rstrb=1 only in T+1; m0_done=1 only in T+3; m0_rdata=0xDEADBEEF; m1 outputs unchanged.
2. m1 write, addr 0x20, wdata 0x12345678, wmask 4'b0011, rstrb=1 -> mem_wmask=0011 and mem_rstrb=0 in T+1; m1_done in T+3; m1_rdata stays 0; memory word low half = 0x5678.
3. After reset, m0 read 0x4 and m1 read 0x8 both requested at T -> m0 served first (done T+3); m1 ACCESS at T+4, done T+6; grant_m1 = 0 then 1.
4. Both requesters held high for 12 cycles -> grants alternate m0, m1, m0, m1; exactly four done pulses at T+3, T+6, T+9, T+12.
5. After one m1 transaction, both request together in a non-done IDLE cycle -> FIXED_PRIO=0 grants m0; after one m0 transaction, same stimulus -> FIXED_PRIO=0 grants m1, FIXED_PRIO=1 grants m0.
6. resetn pulled low mid-ACCESS of an m0 read -> all outputs 0 immediately (asynchronously), no m0_done; after release, held request is served with done 3 cycles after the first IDLE cycle.
